banco_registradores_escrita: RTL and testbench



---
 rtl/banco_registradores_escrita_pkg.sv | 16 +
 rtl/banco_registradores_escrita_fila_depuracao.sv | 60 ++++++
 rtl/banco_registradores_escrita.sv | 141 ++++++++++++++
 tb/tb_banco_registradores_escrita.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_escrita_pkg.sv
// Shared definitions for the MIPS32 general-purpose register file.
// Provides the register count, default data/index widths, the hard-zero
// register index and the sweep controller state type.
package mips_regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/banco_registradores_escrita_fila_depuracao.sv
// Parameterised synchronous FIFO used as the debug write queue.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   push, push_data write one entry (ignored when full)
//   pop             discard the head entry (ignored when empty)
//   full, empty     occupancy flags from the registered count
//   head            entry at the front of the queue
// DEPTH must be a power of two so the pointers wrap by overflow.
module fila_depuracao #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Payload storage needs no reset: it is only observed when count > 0.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/banco_registradores_escrita.sv
// Write side of the MIPS32 register file: 32x32 storage, writeback and
// debug-loader write ports, a software-triggered zero sweep of r1..r31,
// and two combinational read ports with write-through bypass.
// Ports:
//   clock, reset_n             clock, asynchronous active-low reset
//   wb_en, wb_rd, wb_data      pipeline writeback, one write per cycle
//   dbg_valid/dbg_ready,
//   dbg_rd, dbg_data           debug loader writes, queued (valid/ready)
//   clear_req                  pulse to start the zero sweep
//   busy                       sweep in progress, pipeline must stall
//   rs, rt / out_rs, out_rt    read indices and read data
//
// state | meaning
// IDLE  | normal operation: writeback or queued debug writes commit
// CLEAR | sweep writes 0 to register[idx], idx = 1..31, one per cycle
module banco_registradores_escrita #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DBG_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              clear_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt
);

  import mips_regfile_pkg::*;

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [REG_COUNT];

  logic               idle;
  logic               q_push;
  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_head;
  logic [ADDR_W-1:0]  head_rd;
  logic [DATA_W-1:0]  head_data;

  logic              commit_en;
  logic [ADDR_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;

  assign idle      = (state == IDLE);
  assign busy      = ~idle;
  assign dbg_ready = idle & ~q_full;
  assign q_push    = dbg_valid & dbg_ready;
  // The queue head only gets the write port when writeback leaves it free.
  assign q_pop     = idle & ~wb_en & ~q_empty;
  assign {head_rd, head_data} = q_head;

  fila_depuracao #(
    .WIDTH (ENTRY_W),
    .DEPTH (DBG_DEPTH)
  ) u_fila (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (q_push),
    .push_data ({dbg_rd, dbg_data}),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // Writes to r0 still consume their slot (queue entry popped) but never
  // reach storage, so commit_en doubles as the bypass qualifier.
  always_comb begin
    commit_en   = 1'b0;
    commit_rd   = ZERO_REG;
    commit_data = '0;
    if (idle) begin
      if (wb_en) begin
        commit_en   = (wb_rd != ZERO_REG);
        commit_rd   = wb_rd;
        commit_data = wb_data;
      end else if (q_pop) begin
        commit_en   = (head_rd != ZERO_REG);
        commit_rd   = head_rd;
        commit_data = head_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (!idle) begin
      regs[idx] <= '0;
    end else if (commit_en) begin
      regs[commit_rd] <= commit_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= ADDR_W'(1);
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) state <= CLEAR;
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= ADDR_W'(1);
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // During the sweep reads show raw storage, possibly partially cleared.
  assign out_rs = (commit_en && (rs == commit_rd)) ? commit_data : regs[rs];
  assign out_rt = (commit_en && (rt == commit_rd)) ? commit_data : regs[rt];

  // Writeback while busy is lost; the pipeline is required to stall.
  wb_during_clear: assert property (@(posedge clock) disable iff (!reset_n)
                                    !(busy && wb_en));

endmodule

// File: tb/tb_banco_registradores_escrita.sv
module tb_banco_registradores_escrita;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_data = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [31:0] out_rs;
  logic [31:0] out_rt;

  always #5 clock = ~clock;

  banco_registradores_escrita #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .DBG_DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_rd    (dbg_rd),
    .dbg_data  (dbg_data),
    .clear_req (clear_req),
    .busy      (busy),
    .rs        (rs),
    .rt        (rt),
    .out_rs    (out_rs),
    .out_rt    (out_rt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register array, debug queue, and the next register the
  // sweep will zero (0 when no sweep is running).
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic [31:0] m_regs [32];
  entry_t      m_q [$];
  int          m_sweep = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_q.delete();
    m_sweep = 0;
  endfunction

  function automatic logic [31:0] exp_read(logic [4:0] idx);
    if (m_sweep == 0 && idx != 0) begin
      if (wb_en) begin
        if (wb_rd == idx) return wb_data;
      end else if (m_q.size() > 0 && m_q[0].rd == idx) begin
        return m_q[0].data;
      end
    end
    return m_regs[idx];
  endfunction

  function automatic logic exp_ready();
    return (m_sweep == 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic void model_edge();
    bit     can_accept;
    entry_t e;
    if (!reset_n) return;
    if (m_sweep != 0) begin
      m_regs[m_sweep] = '0;
      m_sweep = (m_sweep == 31) ? 0 : m_sweep + 1;
    end else begin
      can_accept = (m_q.size() < DEPTH);
      if (wb_en) begin
        if (wb_rd != 0) m_regs[wb_rd] = wb_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e.rd != 0) m_regs[e.rd] = e.data;
      end
      if (dbg_valid && can_accept) m_q.push_back({dbg_rd, dbg_data});
      if (clear_req) m_sweep = 1;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    dbg_valid = 0; dbg_rd = 0; dbg_data = 0;
    clear_req = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    reset_n = 0;
    model_reset();
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b exp 1", dbg_ready); end
    for (int i = 0; i < 32; i += 7) begin
      rs = 5'(i); rt = 5'(31 - i); #1;
      n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL reset_rs[%0d] got %h exp 0", i, out_rs); end
      n_cmp++; if (out_rt !== 32'h0) begin n_bad++; $display("FAIL reset_rt[%0d] got %h exp 0", 31 - i, out_rt); end
    end
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_wb_bypass();
    wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rs = 5; #1;
    n_cmp++; if (out_rs !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wb_bypass got %h exp deadbeef", out_rs); end
    tick();
    wb_en = 0; #1;
    n_cmp++; if (out_rs !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wb_storage got %h exp deadbeef", out_rs); end
  endtask

  task automatic test_r0();
    wb_en = 1; wb_rd = 0; wb_data = 32'h12345678; rs = 0; rt = 5; #1;
    n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL r0_bypass got %h exp 0", out_rs); end
    tick();
    wb_en = 0; #1;
    n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL r0_storage got %h exp 0", out_rs); end
    n_cmp++; if (out_rt !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r0_other got %h exp deadbeef", out_rt); end
  endtask

  task automatic test_debug_queue();
    wb_en = 1; wb_rd = 7; wb_data = 32'h77777777;
    dbg_valid = 1; dbg_rd = 3; dbg_data = 32'h11; #1;
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dq_ready1 got %0b exp 1", dbg_ready); end
    tick();
    dbg_rd = 4; dbg_data = 32'h22; #1;
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dq_ready2 got %0b exp 1", dbg_ready); end
    tick();
    dbg_rd = 5; dbg_data = 32'h00000BAD; #1;
    n_cmp++; if (dbg_ready !== 1'b0) begin n_bad++; $display("FAIL dq_full got %0b exp 0", dbg_ready); end
    tick();
    wb_en = 0; dbg_valid = 0; rs = 3; #1;
    n_cmp++; if (out_rs !== 32'h11) begin n_bad++; $display("FAIL dq_r3_bypass got %h exp 11", out_rs); end
    n_cmp++; if (dbg_ready !== 1'b0) begin n_bad++; $display("FAIL dq_ready_drain got %0b exp 0", dbg_ready); end
    tick();
    rs = 4; rt = 3; #1;
    n_cmp++; if (out_rs !== 32'h22) begin n_bad++; $display("FAIL dq_r4_bypass got %h exp 22", out_rs); end
    n_cmp++; if (out_rt !== 32'h11) begin n_bad++; $display("FAIL dq_r3_storage got %h exp 11", out_rt); end
    tick();
    rt = 5; #1;
    n_cmp++; if (out_rs !== 32'h22) begin n_bad++; $display("FAIL dq_r4_storage got %h exp 22", out_rs); end
    n_cmp++; if (out_rt !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dq_rejected got %h exp deadbeef", out_rt); end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dq_ready_empty got %0b exp 1", dbg_ready); end
  endtask

  task automatic test_clear_sweep();
    for (int i = 1; i < 32; i++) begin
      wb_en = 1; wb_rd = 5'(i); wb_data = 32'(i);
      tick();
    end
    wb_en = 0; clear_req = 1; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_pre got %0b exp 0", busy); end
    tick();
    clear_req = 0;
    for (int n = 1; n < 32; n++) begin
      rs = 5'(n); rt = 31; #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy[%0d] got %0b exp 1", n, busy); end
      n_cmp++; if (out_rs !== 32'(n)) begin n_bad++; $display("FAIL clr_pre[%0d] got %h exp %h", n, out_rs, 32'(n)); end
      n_cmp++; if (out_rt !== 32'd31) begin n_bad++; $display("FAIL clr_r31[%0d] got %h exp 1f", n, out_rt); end
      tick();
      n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL clr_post[%0d] got %h exp 0", n, out_rs); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_end got %0b exp 0", busy); end
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); #1;
      n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL clr_all[%0d] got %h exp 0", i, out_rs); end
    end
  endtask

  task automatic test_clear_with_queue();
    int cycles;
    dbg_valid = 1; dbg_rd = 9; dbg_data = 32'h99; clear_req = 1; rs = 9; #1;
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL cq_ready got %0b exp 1", dbg_ready); end
    tick();
    dbg_valid = 0; clear_req = 0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL cq_held got %h exp 0", out_rs); end
      n_cmp++; if (dbg_ready !== 1'b0) begin n_bad++; $display("FAIL cq_ready_busy got %0b exp 0", dbg_ready); end
      cycles++;
      tick();
    end
    n_cmp++; if (cycles != 31) begin n_bad++; $display("FAIL cq_busy_len got %0d exp 31", cycles); end
    n_cmp++; if (out_rs !== 32'h99) begin n_bad++; $display("FAIL cq_commit got %h exp 99", out_rs); end
    tick();
    n_cmp++; if (out_rs !== 32'h99) begin n_bad++; $display("FAIL cq_stored got %h exp 99", out_rs); end
  endtask

  task automatic test_reset_mid_sweep();
    wb_en = 1; wb_rd = 20; wb_data = 32'h66;
    tick();
    wb_en = 0; dbg_valid = 1; dbg_rd = 12; dbg_data = 32'h77; clear_req = 1;
    tick();
    dbg_valid = 0; clear_req = 0;
    repeat (9) tick();
    #3 reset_n = 0;
    model_reset();
    rs = 20; rt = 12; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %0b exp 0", busy); end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_ready got %0b exp 1", dbg_ready); end
    n_cmp++; if (out_rs !== 32'h0) begin n_bad++; $display("FAIL mrst_r20 got %h exp 0", out_rs); end
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_rt !== 32'h0) begin n_bad++; $display("FAIL mrst_r12[%0d] got %h exp 0", i, out_rt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy_after[%0d] got %0b exp 0", i, busy); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] e_rs, e_rt;
    for (int c = 0; c < 400; c++) begin
      wb_en     = (m_sweep == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      dbg_valid = ($urandom_range(0, 1) == 1);
      dbg_rd    = 5'($urandom_range(0, 31));
      dbg_data  = $urandom;
      clear_req = ($urandom_range(0, 99) == 0);
      rs        = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      rt        = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? m_q[0].rd : 5'($urandom_range(0, 31));
      #1;
      e_rs = exp_read(rs);
      e_rt = exp_read(rt);
      n_cmp++; if (out_rs !== e_rs) begin n_bad++; $display("FAIL rnd_rs c%0d idx %0d got %h exp %h", c, rs, out_rs, e_rs); end
      n_cmp++; if (out_rt !== e_rt) begin n_bad++; $display("FAIL rnd_rt c%0d idx %0d got %h exp %h", c, rt, out_rt, e_rt); end
      n_cmp++; if (busy !== (m_sweep != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d got %0b exp %0b", c, busy, m_sweep != 0); end
      n_cmp++; if (dbg_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready c%0d got %0b exp %0b", c, dbg_ready, exp_ready()); end
      tick();
    end
    quiet_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wb_bypass();
    test_r0();
    test_debug_queue();
    test_clear_sweep();
    test_clear_with_queue();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
